io_memory_ctrl: RTL and testbench

- Parametrised, byte-addressable, big-endian I/O memory for the MIPS datapath; sits on the I/O bus beside data memory.
- Supports byte, halfword and word accesses.
- Includes a cycle-counted interrupt request generator with an int_r/int_ack handshake.
- Address width, request period and handshake timeout are build-time parameters.

---
 rtl/io_memory_ctrl_pkg.sv | 21 ++
 rtl/io_memory_ctrl_int_timer.sv | 84 ++++++++
 rtl/io_memory_ctrl.sv | 86 ++++++++
 tb/tb_io_memory_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_memory_ctrl_pkg.sv
// io_memory_ctrl shared definitions: access sizes and
// one-hot interrupt FSM states.
package io_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef logic [3:0] state_t;

  localparam int B_COUNT = 0;
  localparam int B_REQ   = 1;
  localparam int B_WAIT  = 2;
  localparam int B_DONE  = 3;

  localparam state_t COUNT    = 4'b0001;
  localparam state_t REQ      = 4'b0010;
  localparam state_t WAIT_LOW = 4'b0100;
  localparam state_t DONE     = 4'b1000;

endpackage

// File: rtl/io_memory_ctrl_int_timer.sv
// io_int_timer: periodic interrupt request with int_ack handshake.
// IO_MEM_REARM_EN re-arms after each handshake; otherwise one-shot.
module io_int_timer
  import io_mem_pkg::*;
#(
  parameter int INT_PERIOD  = 100,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic int_ack,
  output logic int_r,
  output logic int_miss
);

  localparam int TW = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;
  localparam int OW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

`ifdef IO_MEM_REARM_EN
  localparam state_t AFTER_ACK = WAIT_LOW;
`else
  localparam state_t AFTER_ACK = DONE;
`endif

  state_t         state;
  state_t         nxt;
  logic [TW-1:0]  timer;
  logic [OW-1:0]  wait_cnt;
  logic           ack_q;
  logic           ack_edge;
  logic           tmr_done;
  logic           tmo;

  assign ack_edge = int_ack & ~ack_q;
  assign tmr_done = (timer == TW'(INT_PERIOD - 1));

  if (ACK_TIMEOUT > 0) begin : g_tmo
    assign tmo = state[B_REQ] & ~ack_edge &
                 (wait_cnt == OW'(ACK_TIMEOUT - 1));
  end else begin : g_no_tmo
    assign tmo = 1'b0;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= COUNT;
    else       state <= nxt;
  end

  // timer, saturating timeout counter, ack history, miss pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      timer    <= '0;
      wait_cnt <= '0;
      ack_q    <= 1'b0;
      int_miss <= 1'b0;
    end else begin
      ack_q    <= int_ack;
      int_miss <= tmo;
      if (state[B_COUNT] && !tmr_done) timer <= timer + 1'b1;
      else                             timer <= '0;
      if (!state[B_REQ])                       wait_cnt <= '0;
      else if (wait_cnt != OW'(ACK_TIMEOUT))   wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (1'b1)
      state[B_COUNT]: if (tmr_done) nxt = REQ;
      state[B_REQ]:   if (ack_edge) nxt = AFTER_ACK;
      state[B_WAIT]:  if (!int_ack) nxt = COUNT;
      state[B_DONE]:  nxt = DONE;
      default:        nxt = COUNT;
    endcase
  end

  // request is high exactly while waiting for the ack
  always_comb begin
    int_r = state[B_REQ];
  end

endmodule

// File: rtl/io_memory_ctrl.sv
// io_memory_ctrl: big-endian byte-addressable I/O memory plus
// interrupt generator; IO_MEM_REARM_EN selects periodic re-request.
module io_memory_ctrl
  import io_mem_pkg::*;
#(
  parameter int ADDR_BITS   = 12,
  parameter int INT_PERIOD  = 100,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        wr,
  input  logic        rd,
  input  logic [1:0]  size,
  input  logic [31:0] Addr,
  input  logic [31:0] IO_In,
  output logic [31:0] IO_Out,
  input  logic        int_ack,
  output logic        int_r,
  output logic        int_miss
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0]           mem [DEPTH];
  logic [ADDR_BITS-1:0] a0, a1, a2, a3;
  logic                 rd_en, wr_en;
  logic [31:0]          rdata;
  logic                 unused_addr;

  assign unused_addr = ^Addr[31:ADDR_BITS];

  assign a0 = Addr[ADDR_BITS-1:0];
  assign a1 = a0 + ADDR_BITS'(1);
  assign a2 = a0 + ADDR_BITS'(2);
  assign a3 = a0 + ADDR_BITS'(3);

  assign rd_en = cs & rd & ~wr;
  assign wr_en = cs & wr & ~rd;

  // read lane steering, right-justified and zero-extended
  always_comb begin
    rdata = '0;
    unique case (size)
      SZ_BYTE: rdata = {24'h0, mem[a0]};
      SZ_HALF: rdata = {16'h0, mem[a0], mem[a1]};
      SZ_WORD: rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
      default: rdata = '0;
    endcase
  end

  assign IO_Out = rd_en ? rdata : 'z;

  // write lane steering, MSB to the lowest address
  always_ff @(posedge clk) begin
    if (wr_en) begin
      unique case (size)
        SZ_BYTE: mem[a0] <= IO_In[7:0];
        SZ_HALF: begin
          mem[a0] <= IO_In[15:8];
          mem[a1] <= IO_In[7:0];
        end
        SZ_WORD: begin
          mem[a0] <= IO_In[31:24];
          mem[a1] <= IO_In[23:16];
          mem[a2] <= IO_In[15:8];
          mem[a3] <= IO_In[7:0];
        end
        default: ;
      endcase
    end
  end

  io_int_timer #(
    .INT_PERIOD (INT_PERIOD),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_int_timer (
    .clk     (clk),
    .reset   (reset),
    .int_ack (int_ack),
    .int_r   (int_r),
    .int_miss(int_miss)
  );

endmodule

// File: tb/tb_io_memory_ctrl.sv
// tb_io_memory_ctrl: scoreboard bench for io_memory_ctrl memory port
// and interrupt handshake; honours IO_MEM_REARM_EN.
module tb_io_memory_ctrl;

  localparam int AB = 12;
  localparam int DEP = 1 << AB;
  localparam int IP = 100;
  localparam int AT = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, wr, rd;
  logic [1:0]  size;
  logic [31:0] Addr, IO_In;
  wire  [31:0] IO_Out;
  logic        int_ack;
  logic        int_r, int_miss;

  typedef struct {
    bit          z;
    logic [31:0] v;
    string       nm;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mm [DEP];
  bit          sample = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  io_memory_ctrl #(
    .ADDR_BITS  (AB),
    .INT_PERIOD (IP),
    .ACK_TIMEOUT(AT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .wr      (wr),
    .rd      (rd),
    .size    (size),
    .Addr    (Addr),
    .IO_In   (IO_In),
    .IO_Out  (IO_Out),
    .int_ack (int_ack),
    .int_r   (int_r),
    .int_miss(int_miss)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int ix(input logic [31:0] a, input int k);
    return (int'(a[AB-1:0]) + k) % DEP;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a,
                                          input logic [1:0] sz);
    case (sz)
      2'b00:   return {24'h0, mm[ix(a, 0)]};
      2'b01:   return {16'h0, mm[ix(a, 0)], mm[ix(a, 1)]};
      2'b10:   return {mm[ix(a, 0)], mm[ix(a, 1)],
                       mm[ix(a, 2)], mm[ix(a, 3)]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] d);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
    for (int k = 0; k < n; k++)
      mm[ix(a, k)] = d[8*(n-1-k) +: 8];
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // one bus cycle; expectation queued before the edge
  task automatic op(input bit c, input bit w, input bit r,
                    input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] d, input string nm);
    exp_t e;
    cs = c; wr = w; rd = r; size = sz; Addr = a; IO_In = d;
    e.z  = !(c && r && !w);
    e.v  = e.z ? 32'h0 : ref_read(a, sz);
    e.nm = nm;
    exp_q.push_back(e);
    sample = 1'b1;
    @(posedge clk);
    if (c && w && !r) ref_write(a, sz, d);
    #1;
    sample = 1'b0;
  endtask

  // monitor: one pop per bus cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (sample) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.z && IO_Out !== 32'hz) begin
          n_fail++;
          $display("FAIL %s: IO_Out=%h want zzzzzzzz", e.nm, IO_Out);
        end else if (!e.z && IO_Out !== e.v) begin
          n_fail++;
          $display("FAIL %s: IO_Out=%h want %h", e.nm, IO_Out, e.v);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic edges_to_rise(input int bound, output int k);
    k = -1;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clk); #1;
      if (int_r) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int k, hits, misses, first, drops;
    cs = 0; wr = 0; rd = 0; size = 0; Addr = 0; IO_In = 0;
    int_ack = 0; reset = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_int_r", {31'h0, int_r}, 32'h0);
    chk("rst_int_miss", {31'h0, int_miss}, 32'h0);
    op(0, 0, 1, 2'b10, 32'h0, 32'h0, "rst_cs0_z");
    reset = 1'b0;

    for (int i = 0; i < DEP / 4; i++)
      op(1, 1, 0, 2'b10, i * 4, $urandom, "fill_z");

    op(1, 1, 0, 2'b10, 32'h010, 32'hDEADBEEF, "w_word");
    op(1, 0, 1, 2'b10, 32'h010, 32'h0, "r_word_010");
    op(1, 0, 1, 2'b00, 32'h011, 32'h0, "r_byte_011");
    op(1, 1, 0, 2'b01, 32'h020, 32'h1234ABCD, "w_half");
    op(1, 0, 1, 2'b10, 32'h020, 32'h0, "r_word_020");
    op(0, 0, 1, 2'b10, 32'h020, 32'h0, "cs0_z");
    op(1, 1, 1, 2'b10, 32'h010, 32'h55555555, "rdwr_z");
    op(1, 1, 0, 2'b11, 32'h010, 32'hAAAAAAAA, "w_size3");
    op(1, 0, 1, 2'b10, 32'h010, 32'h0, "r_010_kept");
    op(1, 0, 1, 2'b11, 32'h010, 32'h0, "r_size3");
    op(1, 1, 0, 2'b10, 32'hFFE, 32'h11223344, "w_wrap");
    op(1, 0, 1, 2'b00, 32'hFFE, 32'h0, "r_ffe");
    op(1, 0, 1, 2'b00, 32'hFFF, 32'h0, "r_fff");
    op(1, 0, 1, 2'b00, 32'h000, 32'h0, "r_000");
    op(1, 0, 1, 2'b00, 32'h001, 32'h0, "r_001");
    op(1, 0, 1, 2'b10, 32'hFFE, 32'h0, "r_wrap_word");
    op(1, 0, 1, 2'b01, 32'hABCDEFFF, 32'h0, "r_half_hibits");

    for (int i = 0; i < 400; i++)
      op($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
         2'($urandom), $urandom, $urandom, "rand");
    cs = 0; wr = 0; rd = 0;

    do_reset();
    edges_to_rise(IP + 50, k);
    chk("first_rise", k, IP);
    repeat (4) @(posedge clk);
    #1;
    chk("req_hold", {31'h0, int_r}, 32'h1);
    chk("req_no_miss", {31'h0, int_miss}, 32'h0);
    int_ack = 1;
    @(posedge clk); #1;
    chk("ack_drop", {31'h0, int_r}, 32'h0);
    repeat (9) @(posedge clk);
    #1;
    chk("ack_held_low", {31'h0, int_r}, 32'h0);
    int_ack = 0;
`ifdef IO_MEM_REARM_EN
    edges_to_rise(3 * IP, k);
    chk("rearm_rise", k, IP + 1);
`else
    hits = 0;
    repeat (500) begin
      @(posedge clk); #1;
      if (int_r || int_miss) hits++;
    end
    chk("oneshot_quiet", hits, 0);
`endif

    do_reset();
    edges_to_rise(IP + 50, k);
    chk("rise_b", k, IP);
    misses = 0; first = -1; drops = 0;
    for (int i = 1; i <= 2 * AT; i++) begin
      @(posedge clk); #1;
      if (int_miss) begin
        misses++;
        if (first < 0) first = i;
      end
      if (!int_r) drops++;
    end
    chk("miss_count", misses, 1);
    chk("miss_at", first, AT);
    chk("int_r_kept", drops, 0);

    do_reset();
    edges_to_rise(IP + 50, k);
    chk("rise_c", k, IP);
    repeat (AT - 1) @(posedge clk);
    #1;
    int_ack = 1;
    @(posedge clk); #1;
    chk("ack_vs_tmo_miss", {31'h0, int_miss}, 32'h0);
    chk("ack_vs_tmo_req", {31'h0, int_r}, 32'h0);
    int_ack = 0;
    @(posedge clk); #1;
    chk("ack_vs_tmo_late", {31'h0, int_miss}, 32'h0);

    int_ack = 1;
    do_reset();
    edges_to_rise(IP + 50, k);
    chk("rise_ack_held", k, IP);
    repeat (3) @(posedge clk);
    #1;
    chk("no_early_ack", {31'h0, int_r}, 32'h1);

    reset = 1;
    @(posedge clk); #1;
    chk("reset_drop", {31'h0, int_r}, 32'h0);
    reset = 0;
    int_ack = 0;
    edges_to_rise(IP + 50, k);
    chk("restart_rise", k, IP);
    op(1, 0, 1, 2'b10, 32'h010, 32'h0, "keep_010");
    chk("keep_010_model", ref_read(32'h010, 2'b10), 32'hDEADBEEF);

    @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
